xor_swap_seq: RTL and testbench

XOR_SWAP_SEQ -- requirements
Module: xor_swap_seq

---
 rtl/xor_swap_seq.sv | 96 +++++++++
 tb/tb_xor_swap_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/xor_swap_seq.sv
// Sequential in-place XOR swap of two operands over three clock steps.
// A valid/ready handshake on each side; completed swaps are counted modulo 256.
module xor_swap_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [7:0]       swap_count
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   ra_q, ra_d;
  logic [WIDTH-1:0]   rb_q, rb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  // State, operand registers and handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ra_q        <= '0;
      rb_q        <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = S1;
      S1:      state_d = S2;
      S2:      state_d = S3;
      S3:      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates; flags are decoded from the next state so they stay flops
  always_comb begin
    ra_d        = ra_q;
    rb_d        = rb_q;
    cnt_d       = cnt_q;
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ra_d = a_in;
          rb_d = b_in;
        end
      end
      S1:      ra_d = ra_q ^ rb_q;
      S2:      rb_d = ra_q ^ rb_q;
      S3:      ra_d = ra_q ^ rb_q;
      DONE:    if (out_ready) cnt_d = cnt_q + CNT_W'(1);
      default: ;
    endcase
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign a_out      = ra_q;
  assign b_out      = rb_q;
  assign swap_count = cnt_q;

endmodule

// File: tb/tb_xor_swap_seq.sv
// Scoreboard bench for xor_swap_seq: a driver queues expected swapped pairs,
// an independent monitor checks them, their timing and the swap counter.
module tb_xor_swap_seq;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] a_out;
  logic [W-1:0] b_out;
  logic [7:0]   swap_count;

  always #5 clk = ~clk;

  xor_swap_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .a_out      (a_out),
    .b_out      (b_out),
    .swap_count (swap_count)
  );

  typedef struct {
    int a;
    int b;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   model_cnt = 0;
  int   or_mode = 1;   // 0: hold low, 1: hold high, 2: random
  bit   rst_seen = 1'b0;
  bit   prev_ov = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  // Consumer: changes out_ready just after the edge so it is stable at the next one
  always @(posedge clk) begin
    #1;
    case (or_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom);
    endcase
  end

  // Monitor: checks every presented result against the scoreboard head
  always @(negedge clk) begin
    if (rst_seen) begin
      sb.delete();
      model_cnt = 0;
      prev_ov   = 1'b0;
    end else begin
      check("ready_valid_exclusive", int'(in_ready & out_valid), 0);
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          if (!prev_ov) begin
            // result appears on the third edge after the accept edge
            check("latency", cyc - sb[0].acc, 3);
            check("count_before_handshake", int'(swap_count), model_cnt);
          end
          check("a_out", int'(a_out), sb[0].a);
          check("b_out", int'(b_out), sb[0].b);
          if (out_ready) begin
            void'(sb.pop_front());
            model_cnt = (model_cnt + 1) % 256;
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input int a, input int b, output int acc);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = W'(a);
    b_in     = W'(b);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      acc      = -1;
    end else begin
      acc = cyc + 1;
      sb.push_back('{b, a, acc});
      @(negedge clk);
      in_valid = 1'b0;
      a_in     = W'($urandom);
      b_in     = W'($urandom);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!in_ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("idle_timeout", 0, 1);
  endtask

  initial begin
    int acc0, acc1, acc2, t;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_a_out", int'(a_out), 0);
    check("reset_b_out", int'(b_out), 0);
    check("reset_swap_count", int'(swap_count), 0);

    // Basic swap
    send(7, 9, acc0);
    wait_idle();
    check("basic_count", int'(swap_count), 1);

    // Back-to-back pairs
    send(4, 5, acc1);
    send(12, 13, acc2);
    check("accept_spacing", acc2 - acc1, 5);
    wait_idle();
    check("b2b_count", int'(swap_count), 3);

    // Equal operands under back-pressure
    or_mode = 0;
    send(12, 12, acc0);
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 6; i++) begin
      check("bp_out_valid_held", int'(out_valid), 1);
      check("bp_in_ready_low", int'(in_ready), 0);
      check("bp_a_out", int'(a_out), 12);
      check("bp_b_out", int'(b_out), 12);
      @(negedge clk);
    end
    or_mode = 1;
    @(negedge clk);
    check("bp_still_done", int'(out_valid), 1);
    @(negedge clk);
    check("bp_released_idle", int'(in_ready), 1);
    check("bp_count", int'(swap_count), 4);

    // Offer a pair while the block is busy in S2
    send(1, 14, acc0);
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = W'(3);
    b_in     = W'(3);
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk);
    check("busy_no_capture_queue", sb.size(), 0);
    check("busy_no_extra_valid", int'(out_valid), 0);
    check("busy_count", int'(swap_count), 5);

    // Random pairs with random consumer stalls
    or_mode = 2;
    repeat (40) send(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), acc0);
    or_mode = 1;
    wait_idle();
    repeat (3) @(negedge clk);
    check("random_drained", sb.size(), 0);

    // Reset in the middle of a swap
    send(6, 10, acc0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_a_out", int'(a_out), 0);
    check("abort_b_out", int'(b_out), 0);
    check("abort_count", int'(swap_count), 0);
    repeat (6) @(negedge clk);
    check("abort_no_pulse", int'(out_valid), 0);
    check("abort_count_later", int'(swap_count), 0);

    // Counter wrap over 256 swaps
    for (int i = 1; i <= 256; i++) begin
      send(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), acc0);
      wait_idle();
      if (i == 255) check("wrap_255", int'(swap_count), 255);
      if (i == 256) check("wrap_0", int'(swap_count), 0);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
